// File: rtl/d5m_rgb_axis_packer_if.sv
// d5m_rgb_axis_packer_if: 24-bit AXI4-Stream video bus carrying tuser=SOF and tlast=EOL
interface d5m_rgb_axis_packer_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;
    logic [DATA_WIDTH-1:0] tdata;
    modport master (output tvalid, tlast, tuser, tdata, input tready);
    modport slave  (input tvalid, tlast, tuser, tdata, output tready);
endinterface

// File: rtl/d5m_rgb_axis_packer.sv
// d5m_rgb_axis_packer: D5M raster to AXI4-Stream video with FWFT FIFO and frame drop on overflow; D5M_AXIS_STATS_EN adds frame_cnt/line_pixels
module d5m_rgb_axis_packer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  enable,
    input  logic                  ifval,
    input  logic                  ilval,
    input  logic [DATA_WIDTH-1:0] idata,
    d5m_rgb_axis_packer_if.master rgb_m_axis,
    output logic                  overflow
`ifdef D5M_AXIS_STATS_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           line_pixels
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;
    state_t                state;
    logic                  ifval_d, sof_flag, pend_valid, pend_user;
    logic [DATA_WIDTH-1:0] pend_data;
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [DATA_WIDTH+1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH+1:0] rd_entry;
    logic                  pix, empty, full, pop, commit, ovf_now, push;

    assign pix      = ifval && ilval;
    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && rgb_m_axis.tready;
    // pending always leaves the look-ahead register the cycle after it loads; tlast when no pixel follows
    assign commit   = state == S_FRAME && pend_valid;
    assign ovf_now  = commit && full && !pop;
    assign push     = commit && !ovf_now;
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    assign rgb_m_axis.tvalid = !empty;
    assign rgb_m_axis.tuser  = empty ? 1'b0 : rd_entry[DATA_WIDTH+1];
    assign rgb_m_axis.tlast  = empty ? 1'b0 : rd_entry[DATA_WIDTH];
    assign rgb_m_axis.tdata  = empty ? '0 : rd_entry[DATA_WIDTH-1:0];

    // frame FSM and EOL look-ahead register; ifval_d resets high so a frame already open at reset release is skipped
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= S_IDLE;
            ifval_d    <= 1'b1;
            sof_flag   <= 1'b0;
            pend_valid <= 1'b0;
            pend_user  <= 1'b0;
            pend_data  <= '0;
        end else begin
            ifval_d <= ifval;
            case (state)
                S_IDLE: begin
                    pend_valid <= 1'b0;
                    if (ifval && !ifval_d && enable) begin
                        state    <= S_FRAME;
                        sof_flag <= 1'b1;
                    end
                end
                S_FRAME: begin
                    if (ovf_now) begin
                        state      <= S_DROP;
                        pend_valid <= 1'b0;
                    end else begin
                        pend_valid <= pix;
                        if (pix) begin
                            pend_data <= idata;
                            pend_user <= sof_flag;
                            sof_flag  <= 1'b0;
                        end
                        if (!ifval) state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    pend_valid <= 1'b0;
                    if (!ifval) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (ovf_now) overflow <= 1'b1;
        end
    end

    // FIFO storage: {tuser, tlast, tdata}
    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {pend_user, !pix, pend_data};
    end

`ifdef D5M_AXIS_STATS_EN
    logic [15:0] line_cnt;
    logic [15:0] line_next;
    assign line_next = (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 16'd1;

    // completed-frame counter and pixel count of the last committed line
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            frame_cnt   <= '0;
            line_pixels <= '0;
            line_cnt    <= '0;
        end else begin
            if (state != S_FRAME) line_cnt <= '0;
            else if (push && pix) line_cnt <= line_next;
            else if (push) begin
                line_pixels <= line_next;
                line_cnt    <= '0;
            end
            if (state == S_FRAME && !ifval && !ovf_now) frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif
endmodule
